// File: rtl/rr_mux_stream_if.sv
// Stream bundle for rr_mux_stream: M input channels plus one output channel.
// Ports: mode, in_data/in_valid/in_ready (M channels), out_data/out_sel/out_valid/out_ready.
interface rr_mux_stream_if #(
  parameter int N = 32,
  parameter int M = 4
);
  localparam int SW = $clog2(M);

  logic           mode;
  logic [M*N-1:0] in_data;
  logic [M-1:0]   in_valid;
  logic [M-1:0]   in_ready;
  logic [N-1:0]   out_data;
  logic [SW-1:0]  out_sel;
  logic           out_valid;
  logic           out_ready;

  modport master (
    output mode, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );

  modport slave (
    input  mode, in_data, in_valid, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );
endinterface

// File: rtl/rr_mux_stream.sv
// M-input stream mux with round-robin / fixed-priority arbiter and a
// registered output stage. Ports: clk, rst (async high), bus (slave modport).
module rr_mux_stream #(
  parameter int N = 32,
  parameter int M = 4
) (
  input logic          clk,
  input logic          rst,
  rr_mux_stream_if.slave bus
);
  localparam int SW = $clog2(M);

  logic [N-1:0]  data_q;
  logic [SW-1:0] sel_q;
  logic          valid_q;
  logic [SW-1:0] ptr;

  logic          load;
  logic [SW-1:0] base;
  logic          g_any;
  logic [SW-1:0] g_idx;
  logic [SW-1:0] ptr_nxt;
  logic [M-1:0]  rdy;

  // Output slot is free, or is being drained on this edge.
  assign load = !valid_q || bus.out_ready;

  // Fixed priority is round-robin with the search anchored at 0.
  assign base = bus.mode ? '0 : ptr;

  always_comb begin
    int c;
    g_any = 1'b0;
    g_idx = '0;
    c     = 0;
    for (int k = 0; k < M; k++) begin
      c = int'(base) + k;
      if (c >= M) c = c - M;
      if (!g_any && bus.in_valid[c[SW-1:0]]) begin
        g_any = 1'b1;
        g_idx = c[SW-1:0];
      end
    end
  end

  assign ptr_nxt = (g_idx == SW'(M - 1)) ? '0 : g_idx + 1'b1;

  always_comb begin
    rdy = '0;
    for (int i = 0; i < M; i++) begin
      rdy[i] = load && g_any && (g_idx == SW'(i)) && !rst;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
      ptr     <= '0;
    end else if (load) begin
      if (g_any) begin
        valid_q <= 1'b1;
        data_q  <= bus.in_data[int'(g_idx)*N +: N];
        sel_q   <= g_idx;
        if (!bus.mode) ptr <= ptr_nxt;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;
  assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_rr_mux_stream.sv
// Randomized scoreboard bench for rr_mux_stream.
// A transaction-level arbiter model predicts grants; a monitor checks output beats.
module tb_rr_mux_stream;
  localparam int N  = 32;
  localparam int M  = 4;
  localparam int SW = $clog2(M);

  typedef struct packed {
    logic [N-1:0]  d;
    logic [SW-1:0] s;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  rr_mux_stream_if #(.N(N), .M(M)) bus ();
  rr_mux_stream #(.N(N), .M(M)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int passed = 0;

  beat_t        exp_q[$];
  logic [N-1:0] hold[M];
  bit           pend[M];
  int           ptr_m;
  bit           mv;
  int           acc;
  int           p_valid;
  int           p_ready;
  int           mode_pol;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a === e) passed++;
    else $display("FAIL %s: got %0h want %0h", nm, a, e);
  endtask

  task automatic drive();
    if (acc >= 0) pend[acc] = 0;
    for (int i = 0; i < M; i++) begin
      if (!pend[i] && ($urandom % 100) < p_valid) begin
        hold[i] = $urandom;
        pend[i] = 1;
      end
      bus.in_valid[i] = pend[i];
      bus.in_data[i*N +: N] = hold[i];
    end
    bus.out_ready = ($urandom % 100) < p_ready;
    if (mode_pol == 2) begin
      if (($urandom % 100) < 5) bus.mode = ~bus.mode;
    end else begin
      bus.mode = mode_pol[0];
    end
  endtask

  // Arbiter reference: search channels in order from the anchor, first pending wins.
  task automatic model();
    bit ld;
    int g;
    int b;
    int c;
    logic [M-1:0] er;
    chk("out_valid", bus.out_valid, mv);
    ld = !mv || bus.out_ready;
    g  = -1;
    er = '0;
    if (ld) begin
      b = bus.mode ? 0 : ptr_m;
      for (int k = 0; k < M; k++) begin
        c = (b + k) % M;
        if (g < 0 && pend[c]) g = c;
      end
    end
    if (g >= 0) er[g] = 1'b1;
    chk("in_ready", bus.in_ready, er);
    if (g >= 0) begin
      exp_q.push_back('{d: hold[g], s: SW'(g)});
      if (!bus.mode) ptr_m = (g + 1) % M;
      mv = 1;
    end else if (ld) begin
      mv = 0;
    end
    acc = g;
  endtask

  task automatic async_reset();
    for (int i = 0; i < M; i++) begin
      if (!pend[i]) begin
        hold[i] = $urandom;
        pend[i] = 1;
      end
      bus.in_valid[i] = 1'b1;
      bus.in_data[i*N +: N] = hold[i];
    end
    #1 rst = 1'b1;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_sel", bus.out_sel, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    exp_q.delete();
    mv    = 0;
    ptr_m = 0;
    acc   = -1;
    #2 rst = 1'b0;
  endtask

  task automatic step(input bit do_rst);
    @(posedge clk);
    #2;
    drive();
    if (do_rst) async_reset();
    @(negedge clk);
    #1;
    model();
  endtask

  // Monitor: the beat on the output must be the scoreboard head, held while stalled.
  initial begin
    beat_t h;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL underflow: got beat %0h/%0d want none", bus.out_data, bus.out_sel);
        end else begin
          h = exp_q[0];
          chk("out_data", bus.out_data, h.d);
          chk("out_sel", bus.out_sel, h.s);
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.mode = 1'b0;
    bus.in_valid = '0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < M; i++) begin
      pend[i] = 0;
      hold[i] = '0;
    end
    ptr_m = 0;
    mv = 0;
    acc = -1;
    p_valid = 0;
    p_ready = 100;
    mode_pol = 0;
    repeat (2) @(posedge clk);
    #2;
    bus.in_valid = '1;
    #1;
    chk("init_out_valid", bus.out_valid, 0);
    chk("init_out_data", bus.out_data, 0);
    chk("init_out_sel", bus.out_sel, 0);
    chk("init_in_ready", bus.in_ready, 0);
    bus.in_valid = '0;
    @(negedge clk);
    rst = 1'b0;

    for (int ph = 0; ph < 8; ph++) begin
      case (ph)
        0: begin p_valid = 100; p_ready = 100; mode_pol = 0; end
        1: begin p_valid = 30;  p_ready = 100; mode_pol = 0; end
        2: begin p_valid = 100; p_ready = 30;  mode_pol = 0; end
        3: begin p_valid = 100; p_ready = 100; mode_pol = 1; end
        4: begin p_valid = 70;  p_ready = 60;  mode_pol = 2; end
        5: begin p_valid = 50;  p_ready = 50;  mode_pol = 1; end
        6: begin p_valid = 15;  p_ready = 80;  mode_pol = 2; end
        default: begin p_valid = 90; p_ready = 70; mode_pol = 2; end
      endcase
      for (int c = 0; c < 300; c++) step(ph == 4 && c == 150);
    end

    p_valid = 0;
    p_ready = 100;
    mode_pol = 0;
    repeat (12) step(1'b0);
    chk("drain_empty", exp_q.size(), 0);
    chk("drain_valid", bus.out_valid, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
